pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register carrying PC, operand A, operand B and instruction (IR).
//  Replaces fixed-width free-running stage latches with a valid/ready handshake and a 2-entry skid buffer.
//  Adds stall support (backpressure), flush-to-NOP bubble insertion and a saturating bubble counter.
//  Sits between any two processor stages (F/D, D/X, X/M, M/W); one instance per boundary.
// PARAMETERS
//  WIDTH   32            width of each of pc/a/b/ir fields
//  NOP_IR  32'h00000000  IR value presented on empty/flush/reset (WIDTH bits)
//  CNT_W   16            width of bubble_count
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  clear         in   1      synchronous active-high reset
//  flush         in   1      synchronous squash of all held entries
//  in_valid      in   1      upstream has an entry this cycle
//  in_ready      out  1      stage can accept; in_fire = in_valid & in_ready
//  pc_in         in   WIDTH  upstream PC
//  a_in          in   WIDTH  upstream operand A
//  b_in          in   WIDTH  upstream operand B
//  ir_in         in   WIDTH  upstream instruction
//  out_valid     out  1      output entry valid
//  out_ready     in   1      downstream accepts; out_fire = out_valid & out_ready
//  pc_out        out  WIDTH  held PC
//  a_out         out  WIDTH  held operand A
//  b_out         out  WIDTH  held operand B
//  ir_out        out  WIDTH  held instruction (NOP_IR when squashed)
//  bubble_count  out  CNT_W  cycles with out_valid==0 since clear, saturating
// BEHAVIOUR
//  Storage: main entry (drives outputs) + skid entry. State = {EMPTY, FULL, SKID}.
//  in_ready = (state != SKID); driven from state register only, no comb path from out_ready.
//  out_valid = (state != EMPTY).
//  Transitions (no clear/flush):
//   EMPTY: in_fire -> FULL, main<=in.
//   FULL : in_fire&out_fire -> FULL, main<=in; in_fire&!out_fire -> SKID, skid<=in;
//          !in_fire&out_fire -> EMPTY; else hold.
//   SKID : out_fire -> FULL, main<=skid; else hold. (in_ready=0, no capture.)
//  Latency in->out 1 cycle when EMPTY/FULL-draining; throughput 1 entry/cycle sustained.
//  Ordering strictly FIFO; no entry dropped or duplicated.
//  Output fields change only on main load, flush or clear; stable while out_valid & !out_ready.
//  Going EMPTY via out_fire leaves fields at last value (out_valid=0 marks them dead).
//  flush: next state EMPTY, both entries dropped, pc/a/b_out<=0, ir_out<=NOP_IR;
//   same-cycle in_fire is discarded (flush wins); bubble_count unaffected.
//  clear: dominates flush; state EMPTY, pc/a/b_out=0, ir_out=NOP_IR, out_valid=0,
//   in_ready=1 from the first cycle after clear, bubble_count=0. Valid mid-transfer.
//  bubble_count: +1 on each non-clear cycle with out_valid==0; holds at 2^CNT_W-1.
//  Skid entry contents invisible at ports; not reset-sensitive beyond state.
// TESTING
//  1 clear 1 cyc -> out_valid=0, in_ready=1, ir_out=NOP_IR, pc_out=0, bubble_count=0.
//  2 out_ready=1, stream pc=0,4,8,... 8 beats -> same order out, 1-cyc latency, no gaps.
//  3 out_ready=0 while sending pc=0x10,0x14,0x18 -> 0x10 held, 0x14 skidded, in_ready=0,
//     0x18 not taken until in_ready=1; release -> 0x10,0x14,0x18 in order.
//  4 flush in SKID state with in_valid=1 -> next cyc out_valid=0, ir_out=NOP_IR, in_ready=1.
//  5 clear asserted in SKID with out_ready toggling -> EMPTY next cyc, nothing emitted.
//  6 CNT_W=4, idle 20 cycles -> bubble_count saturates at 15; flush leaves it at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register for {pc, a, b, ir} with a valid/ready handshake, a 2-entry skid buffer,
// flush-to-NOP bubble insertion and a saturating count of empty output cycles.
module pipe_stage_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] NOP_IR = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] ir_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] ir_out,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] ir;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_in_entry;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_bubble_count;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  assign w_in_entry = '{pc: pc_in, a: a_in, b: b_in, ir: ir_in};
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and load-enable decode; clear/flush override is applied in the registers.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_FULL;
          w_load_main_in = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_in_fire && w_out_fire) begin
          w_state_nxt    = ST_FULL;
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_SKID;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_FULL;
          w_load_main_skid = 1'b1;
        end else begin
          w_state_nxt = ST_SKID;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State register; handshake flags are registered alongside so neither has a path from out_ready.
  always_ff @(posedge clk) begin
    if (clear || flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_SKID);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Main entry drives the outputs; it is left untouched when draining to EMPTY.
  always_ff @(posedge clk) begin
    if (clear || flush) begin
      r_main <= '{pc: {WIDTH{1'b0}}, a: {WIDTH{1'b0}}, b: {WIDTH{1'b0}}, ir: NOP_IR};
    end else if (w_load_main_in) begin
      r_main <= w_in_entry;
    end else if (w_load_main_skid) begin
      r_main <= r_skid;
    end else begin
      r_main <= r_main;
    end
  end

  // Skid entry has no reset: its contents only matter while the state says SKID.
  always_ff @(posedge clk) begin
    if (w_load_skid && !clear && !flush) begin
      r_skid <= w_in_entry;
    end else begin
      r_skid <= r_skid;
    end
  end

  // Bubble counter: counts empty output cycles, sticks at all-ones, ignores flush.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_bubble_count <= {CNT_W{1'b0}};
    end else if (!r_out_valid && (r_bubble_count != CNT_MAX)) begin
      r_bubble_count <= r_bubble_count + CNT_ONE;
    end else begin
      r_bubble_count <= r_bubble_count;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign pc_out       = r_main.pc;
  assign a_out        = r_main.a;
  assign b_out        = r_main.b;
  assign ir_out       = r_main.ir;
  assign bubble_count = r_bubble_count;

endmodule
